// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and encodings for the two-master data-bus arbiter.
// Address windows, bus widths, slave-select and master-id encodings.
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic [31:0] MEM_END_DEF   = 32'h0000_07FF;
  localparam logic [31:0] TIM_BASE_DEF  = 32'h0000_1000;
  localparam logic [31:0] TIM_END_DEF   = 32'h0000_100F;
  localparam logic [31:0] UART_BASE_DEF = 32'h0000_1010;
  localparam logic [31:0] UART_END_DEF  = 32'h0000_101F;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_TIM  = 2'b10,
    SEL_UART = 2'b11
  } slave_sel_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } master_e;

  function automatic logic is_mapped(input slave_sel_e sel);
    return (sel != SEL_NONE);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_addr_decode.sv
// Combinational byte-address to slave-select decoder.
// Every window is inclusive at both ends; memory starts at address 0.
module bus_addr_decode
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = BUS_ADDR_W,
  parameter logic [ADDR_W-1:0] MEM_END   = ADDR_W'(MEM_END_DEF),
  parameter logic [ADDR_W-1:0] TIM_BASE  = ADDR_W'(TIM_BASE_DEF),
  parameter logic [ADDR_W-1:0] TIM_END   = ADDR_W'(TIM_END_DEF),
  parameter logic [ADDR_W-1:0] UART_BASE = ADDR_W'(UART_BASE_DEF),
  parameter logic [ADDR_W-1:0] UART_END  = ADDR_W'(UART_END_DEF)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output slave_sel_e        sel_o
);

  always_comb begin
    sel_o = SEL_NONE;
    if (addr_i <= MEM_END) begin
      sel_o = SEL_MEM;
    end else if ((addr_i >= TIM_BASE) && (addr_i <= TIM_END)) begin
      sel_o = SEL_TIM;
    end else if ((addr_i >= UART_BASE) && (addr_i <= UART_END)) begin
      sel_o = SEL_UART;
    end else begin
      sel_o = SEL_NONE;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and slave router for two data-side masters.
// Grants are combinational; read data returns to the issuing master one cycle later.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = BUS_ADDR_W,
  parameter int                DATA_W    = BUS_DATA_W,
  parameter logic [ADDR_W-1:0] MEM_END   = ADDR_W'(MEM_END_DEF),
  parameter logic [ADDR_W-1:0] TIM_BASE  = ADDR_W'(TIM_BASE_DEF),
  parameter logic [ADDR_W-1:0] TIM_END   = ADDR_W'(TIM_END_DEF),
  parameter logic [ADDR_W-1:0] UART_BASE = ADDR_W'(UART_BASE_DEF),
  parameter logic [ADDR_W-1:0] UART_END  = ADDR_W'(UART_END_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              s_enable,
  output logic              s_w_enable,
  output logic              s_r_enable,
  output logic [ADDR_W-1:0] s_w_addr,
  output logic [ADDR_W-1:0] s_r_addr,
  output logic [DATA_W-1:0] s_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic [DATA_W-1:0] tim_r_data,
  input  logic [DATA_W-1:0] uart_r_data,
  output logic              unmapped_o
);

  logic              gnt0_s, gnt1_s, any_gnt_s, we_s, hit_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s, rdata_mux_s;
  slave_sel_e        sel_s, rsel_q, rsel_d;
  master_e           last_q, last_d, rown_q, rown_d;
  logic              rvalid_q, rvalid_d, unmapped_q, unmapped_d;

  // Grant selection and routing of the winning master's request; reset forces idle.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (m0_req && m1_req) begin
      gnt0_s = (last_q == OWN_M1);
      gnt1_s = (last_q == OWN_M0);
    end else begin
      gnt0_s = m0_req;
      gnt1_s = m1_req;
    end
    any_gnt_s = gnt0_s | gnt1_s;
    if (gnt1_s) begin
      addr_s  = m1_addr;
      we_s    = m1_we;
      wdata_s = m1_wdata;
    end else if (gnt0_s) begin
      addr_s  = m0_addr;
      we_s    = m0_we;
      wdata_s = m0_wdata;
    end else begin
      addr_s  = '0;
      we_s    = 1'b0;
      wdata_s = '0;
    end
  end

  bus_addr_decode #(
    .ADDR_W    (ADDR_W),
    .MEM_END   (MEM_END),
    .TIM_BASE  (TIM_BASE),
    .TIM_END   (TIM_END),
    .UART_BASE (UART_BASE),
    .UART_END  (UART_END)
  ) u_decode (
    .addr_i (addr_s),
    .sel_o  (sel_s)
  );

  // Slave strobes and next-state of the round-robin pointer and read-return pipeline.
  always_comb begin
    hit_s      = is_mapped(sel_s);
    m0_gnt     = gnt0_s;
    m1_gnt     = gnt1_s;
    s_w_enable = any_gnt_s & we_s & hit_s;
    s_r_enable = any_gnt_s & ~we_s & hit_s;
    s_enable   = any_gnt_s & (sel_s == SEL_MEM);
    s_w_addr   = addr_s;
    s_r_addr   = addr_s;
    s_w_data   = wdata_s;
    last_d     = last_q;
    if (any_gnt_s) begin
      last_d = gnt1_s ? OWN_M1 : OWN_M0;
    end else begin
      last_d = last_q;
    end
    rvalid_d = any_gnt_s & ~we_s;
    if (rvalid_d) begin
      rsel_d = sel_s;
      rown_d = gnt1_s ? OWN_M1 : OWN_M0;
    end else begin
      rsel_d = SEL_NONE;
      rown_d = rown_q;
    end
    unmapped_d = any_gnt_s & ~hit_s;
  end

  // Arbiter state: last-granted pointer plus the one-deep read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= OWN_M1;
      rsel_q     <= SEL_NONE;
      rown_q     <= OWN_M0;
      rvalid_q   <= 1'b0;
      unmapped_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      rsel_q     <= rsel_d;
      rown_q     <= rown_d;
      rvalid_q   <= rvalid_d;
      unmapped_q <= unmapped_d;
    end
  end

  // Read return: steer selected slave data to the owner; reset masks any pending return.
  always_comb begin
    case (rsel_q)
      SEL_MEM:  rdata_mux_s = mem_r_data;
      SEL_TIM:  rdata_mux_s = tim_r_data;
      SEL_UART: rdata_mux_s = uart_r_data;
      default:  rdata_mux_s = '0;
    endcase
    m0_rvalid  = rvalid_q & ~rst & (rown_q == OWN_M0);
    m1_rvalid  = rvalid_q & ~rst & (rown_q == OWN_M1);
    m0_rdata   = m0_rvalid ? rdata_mux_s : '0;
    m1_rdata   = m1_rvalid ? rdata_mux_s : '0;
    unmapped_o = unmapped_q & ~rst;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized check of mem_bus_arbiter against a behavioural bus model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_enable, s_w_enable, s_r_enable, unmapped_o;
  logic [31:0] s_w_addr, s_r_addr, s_w_data;
  logic [31:0] mem_r_data, tim_r_data, uart_r_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: who was granted last, and what the previous cycle owes.
  int exp_last   = 1;
  bit pend_valid = 1'b0;
  int pend_owner = 0;
  int pend_reg   = 0;
  bit pend_unm   = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .s_enable(s_enable), .s_w_enable(s_w_enable), .s_r_enable(s_r_enable),
    .s_w_addr(s_w_addr), .s_r_addr(s_r_addr), .s_w_data(s_w_data),
    .mem_r_data(mem_r_data), .tim_r_data(tim_r_data), .uart_r_data(uart_r_data),
    .unmapped_o(unmapped_o)
  );

  // 0 = unmapped, 1 = memory, 2 = timer, 3 = UART
  function automatic int region(input logic [31:0] a);
    if (a <= 32'h0000_07FF) return 1;
    if (a >= 32'h0000_1000 && a <= 32'h0000_100F) return 2;
    if (a >= 32'h0000_1010 && a <= 32'h0000_101F) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 10))
      0: return 32'h0000_0000;
      1: return 32'h0000_07FF;
      2: return 32'h0000_0800;
      3: return 32'h0000_0FFF;
      4: return 32'h0000_1000;
      5: return 32'h0000_100F;
      6: return 32'h0000_1010;
      7: return 32'h0000_101F;
      8: return 32'h0000_1020;
      9: return $urandom_range(0, 32'h0000_07FF);
      default: return $urandom_range(0, 32'h0000_2FFF);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag, input bit r,
                       input bit q0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit q1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [31:0] md, input logic [31:0] td, input logic [31:0] ud);
    bit          e0, e1, ga, ewe, ev0, ev1;
    logic [31:0] ea, ewd, pd;
    int          rg;
    @(negedge clk);
    rst = r;
    m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    mem_r_data = md; tim_r_data = td; uart_r_data = ud;
    #1;
    if (r) begin
      e0 = 1'b0; e1 = 1'b0;
    end else if (q0 && q1) begin
      e0 = (exp_last == 1); e1 = !e0;
    end else begin
      e0 = q0; e1 = q1;
    end
    ga  = e0 | e1;
    ea  = e1 ? a1 : (e0 ? a0 : 32'h0);
    ewe = e1 ? w1 : (e0 ? w0 : 1'b0);
    ewd = e1 ? d1 : (e0 ? d0 : 32'h0);
    rg  = region(ea);
    pd  = (pend_reg == 1) ? md : (pend_reg == 2) ? td : (pend_reg == 3) ? ud : 32'h0;
    ev0 = !r && pend_valid && pend_owner == 0;
    ev1 = !r && pend_valid && pend_owner == 1;
    chk({tag, ":m0_gnt"}, 32'(m0_gnt), 32'(e0));
    chk({tag, ":m1_gnt"}, 32'(m1_gnt), 32'(e1));
    chk({tag, ":gnt_excl"}, 32'(m0_gnt & m1_gnt), 32'h0);
    chk({tag, ":s_w_enable"}, 32'(s_w_enable), 32'(ga && ewe && rg != 0));
    chk({tag, ":s_r_enable"}, 32'(s_r_enable), 32'(ga && !ewe && rg != 0));
    chk({tag, ":s_enable"}, 32'(s_enable), 32'(ga && rg == 1));
    chk({tag, ":s_w_addr"}, s_w_addr, ea);
    chk({tag, ":s_r_addr"}, s_r_addr, ea);
    chk({tag, ":s_w_data"}, s_w_data, ewd);
    chk({tag, ":m0_rvalid"}, 32'(m0_rvalid), 32'(ev0));
    chk({tag, ":m1_rvalid"}, 32'(m1_rvalid), 32'(ev1));
    chk({tag, ":m0_rdata"}, m0_rdata, ev0 ? pd : 32'h0);
    chk({tag, ":m1_rdata"}, m1_rdata, ev1 ? pd : 32'h0);
    chk({tag, ":unmapped"}, 32'(unmapped_o), 32'(!r && pend_unm));
    @(posedge clk);
    if (r) begin
      exp_last = 1; pend_valid = 1'b0; pend_unm = 1'b0; pend_reg = 0;
    end else begin
      if (ga) exp_last = e1 ? 1 : 0;
      pend_valid = ga && !ewe;
      pend_owner = e1 ? 1 : 0;
      pend_reg   = rg;
      pend_unm   = ga && rg == 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    mem_r_data = 32'h0; tim_r_data = 32'h0; uart_r_data = 32'h0;
    repeat (2) @(posedge clk);

    // reset with both requests held, then contention from the reset state
    cycle("rst_hold", 1'b1, 1'b1, 1'b0, 32'h4, 32'h1, 1'b1, 1'b1, 32'h8, 32'h2,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cycle("cont0", 1'b0, 1'b1, 1'b1, 32'h4, 32'hAA, 1'b1, 1'b1, 32'h1000, 32'hBB, 32'h0, 32'h0, 32'h0);
    cycle("cont1", 1'b0, 1'b1, 1'b1, 32'h4, 32'hAA, 1'b1, 1'b1, 32'h1000, 32'hBB, 32'h0, 32'h0, 32'h0);
    cycle("cont2", 1'b0, 1'b1, 1'b1, 32'h4, 32'hAA, 1'b1, 1'b1, 32'h1000, 32'hBB, 32'h0, 32'h0, 32'h0);
    cycle("cont3", 1'b0, 1'b1, 1'b1, 32'h4, 32'hAA, 1'b1, 1'b1, 32'h1000, 32'hBB, 32'h0, 32'h0, 32'h0);

    // timer read by m1
    cycle("tim_rd", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1004, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle("tim_ret", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hA5A5_0001, 32'h0);

    // pipelined reads m0 then m1
    cycle("pipe_a", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle("pipe_b", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1014, 32'h0, 32'h11, 32'h0, 32'h0);
    cycle("pipe_c", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h22);

    // unmapped write, then unmapped read
    cycle("unm_wr", 1'b0, 1'b1, 1'b1, 32'h2000, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle("unm_rd", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle("unm_ret", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77, 32'h77, 32'h77);

    // reset right after a granted read
    cycle("rst_rd", 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle("rst_mid", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h99, 32'h0, 32'h0);
    #1;
    chk("rst_rsel", 32'(dut.rsel_q), 32'h0);
    cycle("rst_after", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h99, 32'h0, 32'h0);

    // requests held through reset
    cycle("held_rst", 1'b1, 1'b1, 1'b0, 32'h100F, 32'h0, 1'b1, 1'b0, 32'h1010, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle("held_rel", 1'b0, 1'b1, 1'b0, 32'h100F, 32'h0, 1'b1, 1'b0, 32'h1010, 32'h0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
            $urandom(), $urandom(), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
